// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter feeding a single uart_tx byte port through a
// one-byte holding register, with an idle watchdog that reclaims stalled grants.
module uart_tx_arb #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned IDLE_TIMEOUT = 27000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [7:0]           hold_data_q, hold_data_d;
    logic                 hold_valid_q, hold_valid_d;
    logic                 hold_last_q, hold_last_d;
    logic [31:0]          wd_q, wd_d;
    logic                 timeout_q, timeout_d;

    logic [NUM_REQ-1:0]   pick;
    logic [1:0]           pick_idx;
    logic                 valid_g;
    logic                 last_g;
    logic [7:0]           data_g;
    logic                 accept;

    function automatic int unsigned rr_idx(input logic [1:0] p, input int unsigned k);
        return (32'(p) + k) % NUM_REQ;
    endfunction

    // First valid requester after the last owner, wrapping around.
    always_comb begin
        pick     = '0;
        pick_idx = ptr_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (pick == '0 && (req_valid & (NUM_REQ'(1) << rr_idx(ptr_q, k))) != '0) begin
                pick     = NUM_REQ'(1) << rr_idx(ptr_q, k);
                pick_idx = 2'(rr_idx(ptr_q, k));
            end
        end
    end

    always_comb begin
        data_g = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            data_g = data_g | (req_data[i*8 +: 8] & {8{|(grant_q & (NUM_REQ'(1) << i))}});
        end
    end

    assign valid_g = |(req_valid & grant_q);
    assign last_g  = |(req_last & grant_q);
    assign accept  = (state_q == XFER) && !hold_valid_q && valid_g;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        hold_last_d  = hold_last_q;
        wd_d         = wd_q;
        timeout_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick != '0) begin
                    grant_d = pick;
                    ptr_d   = pick_idx;
                    wd_d    = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (accept) begin
                    hold_data_d  = data_g;
                    hold_valid_d = 1'b1;
                    hold_last_d  = last_g;
                    wd_d         = '0;
                    if (last_g) state_d = DRAIN;
                end else if (!hold_valid_q && !valid_g) begin
                    // Fire on the cycle the count would reach the limit, so the
                    // revoke lands exactly IDLE_TIMEOUT idle cycles after emptying.
                    if (IDLE_TIMEOUT != 0 && (wd_q + 32'd1) >= IDLE_TIMEOUT) begin
                        grant_d   = '0;
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        wd_d = wd_q + 32'd1;
                    end
                end
            end
            DRAIN: ;
            default: state_d = IDLE;
        endcase

        // Accept requires an empty hold register, so this never overlaps it.
        if (hold_valid_q && tx_data_ready) begin
            hold_valid_d = 1'b0;
            if (state_q == DRAIN && hold_last_q) begin
                grant_d = '0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            ptr_q        <= 2'(NUM_REQ - 1);
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            hold_last_q  <= hold_last_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
        end
    end

    assign req_ready     = (state_q == XFER && !hold_valid_q) ? grant_q : '0;
    assign tx_data       = hold_data_q;
    assign tx_data_valid = hold_valid_q;
    assign grant         = grant_q;
    assign busy          = (state_q != IDLE);
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: two requesters driven from byte queues,
// transmitted bytes logged with their owner and compared to hand-built lists.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req_data;
    logic [1:0]  req_valid;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    // Queue entries are {last, data}; log entries are {owner, data}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] txlog[$];

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NUM_REQ      (2),
        .IDLE_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .grant         (grant),
        .busy          (busy),
        .timeout       (timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        req_valid[0]    = (q0.size() > 0);
        req_data[7:0]   = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
        req_last[0]     = (q0.size() > 0) ? q0[0][8] : 1'b0;
        req_valid[1]    = (q1.size() > 0);
        req_data[15:8]  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
        req_last[1]     = (q1.size() > 0) ? q1[0][8] : 1'b0;
    endtask

    // One clock: sample handshakes mid-cycle, then update requesters after the edge.
    task automatic step();
        logic a0, a1;
        @(negedge clk);
        a0 = req_valid[0] && req_ready[0];
        a1 = req_valid[1] && req_ready[1];
        if (tx_data_valid && tx_data_ready) txlog.push_back({grant[1], tx_data});
        @(posedge clk);
        #1;
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        drive();
    endtask

    task automatic wait_log(input int n, input string tag);
        int k = 0;
        while (txlog.size() < n && k < 200) begin
            step();
            k++;
        end
        check(tag, txlog.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        txlog.delete();
        drive();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    logic [8:0] exp2[8];
    logic [8:0] exp3[6];
    int         bad;
    int         k;

    initial begin
        tx_data_ready = 1'b1;
        do_reset();

        check("rst_grant", grant, 2'b00);
        check("rst_ready", req_ready, 2'b00);
        check("rst_txv", tx_data_valid, 1'b0);
        check("rst_txd", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_tmo", timeout, 1'b0);

        // Single 3-byte packet from requester 0.
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b1, 8'h43});
        drive();
        step();
        check("t1_grant", grant, 2'b01);
        check("t1_ready", req_ready, 2'b01);
        check("t1_txv0", tx_data_valid, 1'b0);
        step();
        check("t1_txv1", tx_data_valid, 1'b1);
        check("t1_txd1", tx_data, 8'h41);
        check("t1_rdy_full", req_ready, 2'b00);
        wait_log(3, "t1_wait");
        check("t1_b0", txlog[0], {1'b0, 8'h41});
        check("t1_b1", txlog[1], {1'b0, 8'h42});
        check("t1_b2", txlog[2], {1'b0, 8'h43});
        check("t1_busy_drop", busy, 1'b0);
        check("t1_grant_end", grant, 2'b00);

        // Fairness: both requesters with two 2-byte packets each.
        do_reset();
        q0.push_back({1'b0, 8'hA0}); q0.push_back({1'b1, 8'hA1});
        q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
        q1.push_back({1'b0, 8'hB0}); q1.push_back({1'b1, 8'hB1});
        q1.push_back({1'b0, 8'hB2}); q1.push_back({1'b1, 8'hB3});
        exp2 = '{{1'b0, 8'hA0}, {1'b0, 8'hA1}, {1'b1, 8'hB0}, {1'b1, 8'hB1},
                 {1'b0, 8'hA2}, {1'b0, 8'hA3}, {1'b1, 8'hB2}, {1'b1, 8'hB3}};
        drive();
        wait_log(8, "t2_wait");
        for (int i = 0; i < 8; i++) begin
            if (i < txlog.size()) check($sformatf("t2_b%0d", i), txlog[i], exp2[i]);
        end

        // No interleave: requester 1 shows up mid-way through a 4-byte packet.
        txlog.delete();
        q0.push_back({1'b0, 8'hC0}); q0.push_back({1'b0, 8'hC1});
        q0.push_back({1'b0, 8'hC2}); q0.push_back({1'b1, 8'hC3});
        exp3 = '{{1'b0, 8'hC0}, {1'b0, 8'hC1}, {1'b0, 8'hC2}, {1'b0, 8'hC3},
                 {1'b1, 8'hD0}, {1'b1, 8'hD1}};
        drive();
        bad = 0;
        k   = 0;
        while (txlog.size() < 4 && k < 100) begin
            if (req_ready[1]) bad++;
            step();
            k++;
            if (k == 3) begin
                q1.push_back({1'b0, 8'hD0});
                q1.push_back({1'b1, 8'hD1});
                drive();
            end
        end
        if (req_ready[1]) bad++;
        check("t3_wait", txlog.size(), 4);
        check("t3_r1_ready_early", bad, 0);
        check("t3_idle_gap", grant, 2'b00);
        step();
        check("t3_grant1", grant, 2'b10);
        wait_log(6, "t3_wait2");
        for (int i = 0; i < 6; i++) begin
            if (i < txlog.size()) check($sformatf("t3_b%0d", i), txlog[i], exp3[i]);
        end

        // Stall: uart_tx not ready for 500 cycles with 0x55 held.
        txlog.delete();
        tx_data_ready = 1'b0;
        q0.push_back({1'b0, 8'h55});
        q0.push_back({1'b1, 8'h66});
        drive();
        step();
        step();
        check("t4_txv", tx_data_valid, 1'b1);
        check("t4_txd", tx_data, 8'h55);
        bad = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (tx_data_valid !== 1'b1 || tx_data !== 8'h55 || req_ready !== 2'b00 ||
                timeout !== 1'b0 || grant !== 2'b01) bad++;
        end
        check("t4_stall_bad_cycles", bad, 0);
        tx_data_ready = 1'b1;
        wait_log(2, "t4_wait");
        check("t4_b0", txlog[0], {1'b0, 8'h55});
        if (txlog.size() > 1) check("t4_b1", txlog[1], {1'b0, 8'h66});
        step();
        check("t4_busy_end", busy, 1'b0);

        // Watchdog: one non-last byte then silence, requester 1 waiting.
        txlog.delete();
        q0.push_back({1'b0, 8'h77});
        drive();
        step();
        check("t5_grant0", grant, 2'b01);
        q1.push_back({1'b1, 8'h88});
        drive();
        step();
        check("t5_txv", tx_data_valid, 1'b1);
        step();
        check("t5_log", txlog.size(), 1);
        check("t5_hold_empty", tx_data_valid, 1'b0);
        k = 0;
        while (timeout !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        check("t5_tmo_delay", k, 16);
        check("t5_grant_revoked", grant, 2'b00);
        check("t5_busy", busy, 1'b0);
        step();
        check("t5_tmo_pulse", timeout, 1'b0);
        check("t5_grant1", grant, 2'b10);
        wait_log(2, "t5_wait");
        if (txlog.size() > 1) check("t5_b1", txlog[1], {1'b1, 8'h88});

        // Reset during byte 2 of 4.
        step();
        txlog.delete();
        q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h22});
        q0.push_back({1'b0, 8'h33}); q0.push_back({1'b1, 8'h44});
        drive();
        k = 0;
        while (!(tx_data_valid === 1'b1 && tx_data === 8'h22) && k < 50) begin
            step();
            k++;
        end
        check("t6_found_b2", tx_data, 8'h22);
        rst_n = 1'b0;
        #1;
        check("t6_grant", grant, 2'b00);
        check("t6_ready", req_ready, 2'b00);
        check("t6_txv", tx_data_valid, 1'b0);
        check("t6_txd", tx_data, 8'h00);
        check("t6_busy", busy, 1'b0);
        check("t6_tmo", timeout, 1'b0);
        q0.delete();
        q1.delete();
        q1.push_back({1'b1, 8'h99});
        q0.push_back({1'b1, 8'hAA});
        drive();
        step();
        step();
        rst_n = 1'b1;
        step();
        check("t6_first_grant", grant, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Packet-level round-robin arbiter that shares one `uart_tx` byte interface between `NUM_REQ` byte-stream requesters, such as the banner/string sender and the RX echo path. Each requester owns the transmitter from its first byte to its `last`-flagged byte, so messages never interleave. A one-byte holding register sits between the requesters and `uart_tx`. An idle watchdog reclaims the grant from a requester that stalls mid-packet.

## Interface
- `NUM_REQ`, 2, number of requesters, legal range 2..4.
- `IDLE_TIMEOUT`, 27000, cycles a granted requester may hold the grant with no byte offered (1 ms at 27 MHz). A value of 0 disables the watchdog.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_data` input NUM_REQ*8: requester i byte is `req_data[i*8 +: 8]`.
- `req_valid` input NUM_REQ: requester i offers a byte.
- `req_last` input NUM_REQ: the offered byte ends requester i's packet.
- `req_ready` output NUM_REQ: requester i byte is accepted this cycle when `req_valid[i] && req_ready[i]`.
- `tx_data` output 8: byte to `uart_tx`.
- `tx_data_valid` output 1: byte valid to `uart_tx`.
- `tx_data_ready` input 1: from `uart_tx`. It must not depend combinationally on `tx_data_valid`.
- `grant` output NUM_REQ: one-hot current owner, or all zero.
- `busy` output 1: high whenever the state is not IDLE.
- `timeout` output 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- States:
  - IDLE: no owner.
  - XFER: owner is streaming bytes.
  - DRAIN: owner's last byte is held, waiting for `uart_tx`.
- Reset values:
  - State IDLE; `grant`, `req_ready`, `tx_data_valid`, `busy`, `timeout` all 0; `tx_data` 8'h00.
  - Holding register empty.
  - Round-robin pointer `ptr` = NUM_REQ-1, so requester 0 has first priority.
- IDLE:
  - If any `req_valid` is high, scan from `ptr+1` modulo NUM_REQ. The first requester found with valid high becomes `g`.
  - Set `grant <= onehot(g)`, `ptr <= g`, go to XFER.
  - Otherwise stay in IDLE.
- XFER, accept side:
  - `req_ready[g] = (state == XFER) && !hold_valid`. All other `req_ready` bits are 0. `req_ready` is combinational from registered state only.
  - On accept: `hold_data <= req_data[g]`, `hold_valid <= 1`, `hold_last <= req_last[g]`, clear the watchdog counter.
  - If `req_last[g]` is set on the accept, go to DRAIN.
- Transmit side, all states:
  - `tx_data = hold_data` and `tx_data_valid = hold_valid`, both registered.
  - On `tx_data_valid && tx_data_ready`: `hold_valid <= 0`.
  - If this occurs in DRAIN: `grant <= 0` and go to IDLE.
- Watchdog:
  - Counts in XFER while `!hold_valid && !req_valid[g]`, and holds its value otherwise. It is cleared on entry to XFER and on every accept.
  - When the count reaches IDLE_TIMEOUT: `grant <= 0`, state IDLE, `timeout` pulses for one cycle.
  - The partial packet is abandoned; no byte is fabricated.
- Requests from non-owners are ignored while an owner exists, and they stay pending. A requester must hold `req_valid` and `req_data` stable until accepted.
- Counter width is 32 bits; the comparison uses `>=`.

## Timing
- Arbitration latency:
  - `req_valid` high in cycle 0, with state IDLE → `grant` and `req_ready` high in cycle 1.
  - Byte accepted at the end of cycle 1 → `tx_data_valid` high in cycle 2.
- Throughput: at most one byte every 2 cycles, since `req_ready` drops while the hold register is full. This is far above the UART rate.
- Packet turnaround: the last byte's tx handshake is in cycle n → IDLE in cycle n+1 → next grant in cycle n+2.
- Simultaneous events:
  - Accept and drain cannot coincide, because `req_ready` requires the hold register to be empty.
  - If the watchdog terminal count and a `req_valid[g]` rise fall in the same cycle, the watchdog does not fire; the counter only advances while valid is low.
- A one-byte packet (`req_last` set on the first byte) goes XFER→DRAIN on that accept.
- Reset asserted mid-packet clears everything immediately and asynchronously. A byte already handed to `uart_tx` is that block's concern.

## Test plan
- **Single packet:** requester 0 sends 3 bytes 0x41, 0x42, 0x43 (last on 0x43), with `tx_data_ready` = 1.
  - Expected: `grant` = 01 in cycle 1; `tx_data` sequence 41, 42, 43; `busy` drops 1 cycle after the 0x43 handshake.
- **Fairness:** both requesters continuously offer 2-byte packets.
  - Expected: grants alternate 0, 1, 0, 1; no byte of requester 1 appears between requester 0's first and last byte.
- **No interleave:** requester 1 raises `req_valid` mid-way through requester 0's 4-byte packet.
  - Expected: `req_ready[1]` stays 0 until requester 0's last byte drains; requester 1 is then granted 2 cycles after that handshake.
- **Stall:** hold `tx_data_ready` = 0 for 500 cycles with byte 0x55 in the hold register.
  - Expected: `tx_data_valid` = 1 and `tx_data` = 0x55 stable throughout; `req_ready` = 0; no timeout.
- **Watchdog:** with IDLE_TIMEOUT = 16, requester 0 sends 1 non-last byte, then drops `req_valid`.
  - Expected: `timeout` pulses 16 cycles after the hold register empties; `grant` = 0; a pending requester 1 is granted next cycle.
- **Reset mid-packet:** pulse `rst_n` low during byte 2 of 4.
  - Expected: all outputs 0 immediately. After release, requester 0 wins first.
